// File: rtl/mod_arith_sequencer.sv
// Command sequencer that runs modular add/sub/mul through one external
// combinational modular add/sub unit. Multiply is an MSB-first double-and-add loop over b.
module mod_arith_sequencer #(
    parameter int W = 4,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         err,
    output logic         au_s,
    output logic [W-1:0] au_x,
    output logic [W-1:0] au_y,
    input  logic [W-1:0] au_z
);

    localparam int            CW      = (W > 1) ? $clog2(W) : 1;
    localparam logic [W:0]    M_EXT   = (W+1)'(M);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);

    typedef enum logic [2:0] {IDLE, EXEC, DBL, ADD, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    op_r, op_nx;
    logic [W-1:0]  a_r, a_nx;
    logic [W-1:0]  b_r, b_nx;
    logic [W-1:0]  acc, acc_nx;
    logic [W-1:0]  result_r, result_nx;
    logic          err_r, err_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          cmd_bad;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign result    = result_r;
    assign err       = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            result_r <= '0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_nx;
            acc      <= acc_nx;
            cnt      <= cnt_nx;
            result_r <= result_nx;
            err_r    <= err_nx;
        end
    end

    // Operand latches are only consumed after a fresh accept, so they need no reset.
    always_ff @(posedge clk) begin
        op_r <= op_nx;
        a_r  <= a_nx;
        b_r  <= b_nx;
    end

    always_comb begin
        state_nx  = state;
        op_nx     = op_r;
        a_nx      = a_r;
        b_nx      = b_r;
        acc_nx    = acc;
        cnt_nx    = cnt;
        result_nx = result_r;
        err_nx    = err_r;
        au_s      = 1'b0;
        au_x      = '0;
        au_y      = '0;
        cmd_bad   = (op == 2'b11) || ({1'b0, a} >= M_EXT) || ({1'b0, b} >= M_EXT);

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    op_nx  = op;
                    a_nx   = a;
                    b_nx   = b;
                    acc_nx = '0;
                    cnt_nx = CNT_TOP;
                    if (cmd_bad) begin
                        result_nx = '0;
                        err_nx    = 1'b1;
                        state_nx  = DONE;
                    end else if (op == 2'b10) begin
                        state_nx = DBL;
                    end else begin
                        state_nx = EXEC;
                    end
                end
            end
            EXEC: begin
                au_x      = a_r;
                au_y      = b_r;
                au_s      = op_r[0];
                result_nx = au_z;
                err_nx    = 1'b0;
                state_nx  = DONE;
            end
            DBL: begin
                au_x   = acc;
                au_y   = acc;
                acc_nx = au_z;
                // A set bit goes to ADD without consuming cnt; ADD steps to the next bit.
                if (b_r[cnt]) begin
                    state_nx = ADD;
                end else if (cnt == '0) begin
                    result_nx = au_z;
                    err_nx    = 1'b0;
                    state_nx  = DONE;
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            ADD: begin
                au_x   = acc;
                au_y   = a_r;
                acc_nx = au_z;
                if (cnt == '0) begin
                    result_nx = au_z;
                    err_nx    = 1'b0;
                    state_nx  = DONE;
                end else begin
                    cnt_nx   = cnt - CW'(1);
                    state_nx = DBL;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mod_arith_sequencer.sv
// Directed bench for mod_arith_sequencer with W=4, M=8; the shared unit is
// modelled as (x +/- y) mod 8 and expected results flow through a scoreboard queue.
module tb_mod_arith_sequencer;

    localparam int W = 4;
    localparam int M = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         err;
    logic         au_s;
    logic [W-1:0] au_x;
    logic [W-1:0] au_y;
    logic [W-1:0] au_z;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mod_arith_sequencer #(.W(W), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err),
        .au_s      (au_s),
        .au_x      (au_x),
        .au_y      (au_y),
        .au_z      (au_z)
    );

    // Model of the shared modular add/sub unit
    always_comb begin
        if (au_s) au_z = 4'((int'(au_x) - int'(au_y) + M) % M);
        else      au_z = 4'((int'(au_x) + int'(au_y)) % M);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb);
        exp_t e;
        e.err = (o == 2'b11) || (int'(xa) >= M) || (int'(xb) >= M);
        e.res = '0;
        e.lat = 0;  // an error is visible straight off the accept edge
        if (!e.err) begin
            case (o)
                2'b00: e.res = 4'((int'(xa) + int'(xb)) % M);
                2'b01: e.res = 4'((int'(xa) - int'(xb) + M) % M);
                default: e.res = 4'((int'(xa) * int'(xb)) % M);
            endcase
            e.lat = (o == 2'b10) ? (W + $countones(xb)) : 1;
        end
        return e;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_before_cmd", 32'(in_ready), 32'd1);
    endtask

    // Issue one command; hold>0 keeps out_ready low for that many cycles in DONE.
    task automatic run_cmd(input logic [1:0] o, input logic [W-1:0] xa, input logic [W-1:0] xb, input int hold);
        exp_t e;
        int   lat;
        wait_ready();
        sb.push_back(model(o, xa, xb));
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        op        = o;
        a         = xa;
        b         = xb;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (o != 2'b10 && o != 2'b11 && int'(xa) < M && int'(xb) < M) begin
            chk("exec_au_s", 32'(au_s), 32'(o[0]));
            chk("exec_au_x", 32'(au_x), 32'(xa));
            chk("exec_au_y", 32'(au_y), 32'(xb));
        end
        lat = 0;
        while (!out_valid && lat < 50) begin
            chk("busy_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk("out_valid_rise", 32'(out_valid), 32'd1);
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("result", 32'(result), 32'(e.res));
            chk("err", 32'(err), 32'(e.err));
            chk("latency", 32'(lat), 32'(e.lat));
        end
        chk("done_au_idle", {29'd0, au_s, au_x == 4'd0, au_y == 4'd0}, 32'd3);
        if (hold > 0) begin
            in_valid = 1'b1;
            op       = 2'b00;
            a        = 4'd1;
            b        = 4'd1;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_out_valid", 32'(out_valid), 32'd1);
                chk("hold_result", 32'(result), 32'(e.res));
                chk("hold_in_ready", 32'(in_ready), 32'd0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op        = 2'b00;
        a         = '0;
        b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_au", {28'd0, au_s, au_x == 4'd0, au_y == 4'd0, 1'b0}, 32'd6);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        run_cmd(2'b00, 4'd5, 4'd6, 0);   // 3
        run_cmd(2'b01, 4'd2, 4'd5, 0);   // 5
        run_cmd(2'b10, 4'd3, 4'd5, 0);   // 7
        run_cmd(2'b10, 4'd7, 4'd7, 0);   // 1
        run_cmd(2'b10, 4'd6, 4'd0, 0);   // 0
        run_cmd(2'b00, 4'd9, 4'd1, 0);   // err
        run_cmd(2'b11, 4'd1, 4'd2, 0);   // err
        run_cmd(2'b01, 4'd2, 4'd12, 0);  // err on b
        run_cmd(2'b00, 4'd3, 4'd4, 0);   // 7, err cleared
        run_cmd(2'b10, 4'd3, 4'd5, 5);   // backpressure
        run_cmd(2'b00, 4'd2, 4'd3, 0);   // 5

        // Reset in the third cycle of mul 7*7
        wait_ready();
        in_valid = 1'b1;
        op       = 2'b10;
        a        = 4'd7;
        b        = 4'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready_after", 32'(in_ready), 32'd1);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        seen_valid = 0;
        repeat (8) begin
            if (out_valid) seen_valid++;
            @(posedge clk); #1;
        end
        chk("midrst_no_out_valid", 32'(seen_valid), 32'd0);
        run_cmd(2'b00, 4'd1, 4'd1, 0);   // 2

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
